pipeline_hazard_controller: RTL and testbench

Sequencing and hazard controller for the five-stage SPARC-subset pipeline (IF, ID, EX, MEM, WB). It tracks the destination register of every in-flight instruction and drives the PC/nPC and IF/ID load enables. It also drives the control-signal NOP mux select, the delay-slot annul, the next-PC source and the operand forwarding selects. It sits beside the ID stage, consumes the control unit outputs for the instruction in ID, and replaces the hard-wired LE=1 / S=0 ties currently on those registers.

---
 rtl/sparc_pipe_pkg.sv | 64 ++++++
 rtl/hazard_scoreboard.sv | 69 ++++++
 rtl/pipeline_hazard_controller.sv | 173 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pipe_pkg.sv
// Shared definitions for the SPARC-subset pipeline sequencing logic.
// Holds the operand-forward and next-PC select encodings, the hazard FSM
// state type, the scoreboard entry layout and the per-source match helper.
package sparc_pipe_pkg;

    // Operand source selects driven to the ALU/store-data muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Next-PC source selects
    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_TGT  = 2'b01;
    localparam logic [1:0] PCSEL_JMPL = 2'b10;

    // Storage width of a scoreboard destination field; register addresses
    // up to this width are zero-extended into it.
    localparam int SB_RD_W = 8;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // One in-flight instruction: destination, writes-RF, is-a-load
    typedef struct packed {
        logic [SB_RD_W-1:0] rd;
        logic               wr;
        logic               ld;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{rd: {SB_RD_W{1'b0}}, wr: 1'b0, ld: 1'b0};

    // An entry supplies a source only if it writes the RF and targets a
    // register other than %g0.
    function automatic logic sb_hit(input sb_entry_t e, input logic [SB_RD_W-1:0] src);
        return e.wr && (e.rd != {SB_RD_W{1'b0}}) && (e.rd == src);
    endfunction

    // Youngest matching producer wins: EX before MEM before WB.
    function automatic logic [1:0] fwd_pick(
        input logic               use_src,
        input logic [SB_RD_W-1:0] src,
        input sb_entry_t          ex_e,
        input sb_entry_t          mem_e,
        input sb_entry_t          wb_e
    );
        logic [1:0] sel;
        if (!use_src) begin
            sel = FWD_RF;
        end else if (sb_hit(ex_e, src)) begin
            sel = FWD_EX;
        end else if (sb_hit(mem_e, src)) begin
            sel = FWD_MEM;
        end else if (sb_hit(wb_e, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry destination scoreboard (EX, MEM, WB) that shifts every cycle,
// plus the priority match for the three ID source fields.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   bubble_i               load an empty entry into EX instead of the ID instr
//   rd_i, wr_i, ld_i       destination / RF-write / load flag of the ID instr
//   use_x_i, src_x_i       source valid + address for rs1 (a), rs2 (b), rd (d)
//   fwd_x_o                forward select for each source
//   ex_ld_o                the EX entry is a load
module hazard_scoreboard
    import sparc_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bubble_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             wr_i,
    input  logic             ld_i,
    input  logic             use_a_i,
    input  logic [REG_W-1:0] src_a_i,
    input  logic             use_b_i,
    input  logic [REG_W-1:0] src_b_i,
    input  logic             use_d_i,
    input  logic [REG_W-1:0] src_d_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       fwd_d_o,
    output logic             ex_ld_o
);

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d;

    // Entry entering EX: the ID instruction, or a bubble
    always_comb begin
        ex_d = SB_EMPTY;
        if (bubble_i) begin
            ex_d = SB_EMPTY;
        end else begin
            ex_d.rd = SB_RD_W'(rd_i);
            ex_d.wr = wr_i;
            ex_d.ld = ld_i;
        end
    end

    // Shift register EX -> MEM -> WB
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Per-source producer lookup
    always_comb begin
        fwd_a_o = fwd_pick(use_a_i, SB_RD_W'(src_a_i), ex_q, mem_q, wb_q);
        fwd_b_o = fwd_pick(use_b_i, SB_RD_W'(src_b_i), ex_q, mem_q, wb_q);
        fwd_d_o = fwd_pick(use_d_i, SB_RD_W'(src_d_i), ex_q, mem_q, wb_q);
        ex_ld_o = ex_q.ld;
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing and hazard controller for the five-stage SPARC-subset pipeline.
// Tracks in-flight destinations, resolves operand forwarding, inserts a
// one-cycle bubble on load-use, and steers PC/nPC/IF-ID for delayed branches.
// Ports:
//   Clk, R                        clock, synchronous active-low reset
//   id_rs1/rs2/rd, id_uses_*      source fields of the ID instruction
//   id_rf_enable, id_load_instr   control unit outputs for the ID instruction
//   id_b/call/jmpl_instr          control-transfer type in ID
//   id_cond_true, id_ba, id_29_a  branch condition, branch-always, annul bit
//   pc_le, npc_le, ifid_le        load enables
//   cu_nop_sel                    force control signals to zero (bubble)
//   ifid_annul                    IF/ID loads a NOP on the next edge
//   pc_sel                        next-PC source
//   fwd_a, fwd_b, fwd_d           operand source for rs1/rs2/rd
//   stall_cnt                     saturating load-use stall counter
module pipeline_hazard_controller
    import sparc_pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_uses_rd,
    input  logic             id_rf_enable,
    input  logic             id_load_instr,
    input  logic             id_b_instr,
    input  logic             id_call_instr,
    input  logic             id_jmpl_instr,
    input  logic             id_cond_true,
    input  logic             id_ba,
    input  logic             id_29_a,
    output logic             pc_le,
    output logic             npc_le,
    output logic             ifid_le,
    output logic             cu_nop_sel,
    output logic             ifid_annul,
    output logic [1:0]       pc_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_d,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_e        state_q, state_d;
    logic             annul_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0] fwd_a_s, fwd_b_s, fwd_d_s;
    logic       ex_ld_s;
    logic       hazard_s;
    logic       stall_entry_s;
    logic       taken_s;
    logic       annul_s;

    // The instruction after an annul arrives as a NOP, so it leaves no
    // destination behind; a load-use stall likewise sends a bubble to EX.
    hazard_scoreboard #(
        .REG_W (REG_W)
    ) u_scoreboard (
        .clk_i    (Clk),
        .rst_ni   (R),
        .bubble_i (hazard_s | annul_q),
        .rd_i     (id_rd),
        .wr_i     (id_rf_enable),
        .ld_i     (id_load_instr),
        .use_a_i  (id_uses_rs1),
        .src_a_i  (id_rs1),
        .use_b_i  (id_uses_rs2),
        .src_b_i  (id_rs2),
        .use_d_i  (id_uses_rd),
        .src_d_i  (id_rd),
        .fwd_a_o  (fwd_a_s),
        .fwd_b_o  (fwd_b_s),
        .fwd_d_o  (fwd_d_s),
        .ex_ld_o  (ex_ld_s)
    );

    // A source forwarded from EX already implies wr=1, rd!=0 and a used,
    // matching field, so a load in EX plus any EX-forward is a load-use.
    assign hazard_s = ex_ld_s & ((fwd_a_s == FWD_EX) |
                                 (fwd_b_s == FWD_EX) |
                                 (fwd_d_s == FWD_EX));

    // Delayed-branch decode for the instruction in ID
    assign taken_s = id_call_instr | id_jmpl_instr | (id_b_instr & id_cond_true);
    assign annul_s = id_b_instr & id_29_a & (~id_cond_true | id_ba);

    // State, annul flag and stall counter registers
    always_ff @(posedge Clk) begin
        if (!R) begin
            state_q     <= ST_RUN;
            annul_q     <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            annul_q     <= ifid_annul;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic: a stall always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hazard_s) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Output logic: enables, bubble select, annul and next-PC source
    always_comb begin
        stall_entry_s = 1'b0;
        pc_le         = 1'b1;
        npc_le        = 1'b1;
        ifid_le       = 1'b1;
        cu_nop_sel    = 1'b0;
        ifid_annul    = 1'b0;
        pc_sel        = PCSEL_SEQ;

        case (state_q)
            ST_RUN:   stall_entry_s = hazard_s;
            ST_STALL: stall_entry_s = 1'b0;
            default:  stall_entry_s = 1'b0;
        endcase

        if (!R) begin
            cu_nop_sel = 1'b1;
        end else if (hazard_s) begin
            // Hold the ID instruction; any CTI it carries resolves next cycle
            pc_le      = 1'b0;
            npc_le     = 1'b0;
            ifid_le    = 1'b0;
            cu_nop_sel = 1'b1;
        end else begin
            ifid_annul = annul_s;
            if (id_jmpl_instr) begin
                pc_sel = PCSEL_JMPL;
            end else if (taken_s) begin
                pc_sel = PCSEL_TGT;
            end else begin
                pc_sel = PCSEL_SEQ;
            end
        end
    end

    // Saturating count of stall entries
    always_comb begin
        if (stall_entry_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    assign fwd_a     = R ? fwd_a_s : FWD_RF;
    assign fwd_b     = R ? fwd_b_s : FWD_RF;
    assign fwd_d     = R ? fwd_d_s : FWD_RF;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios
// followed by random instruction streams, compared against a reference model
// that keeps the last three issued instructions in an array.
module tb_pipeline_hazard_controller;

    logic       Clk = 1'b0;
    logic       R;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_uses_rd;
    logic       id_rf_enable, id_load_instr;
    logic       id_b_instr, id_call_instr, id_jmpl_instr;
    logic       id_cond_true, id_ba, id_29_a;

    logic        pc_le, npc_le, ifid_le, cu_nop_sel, ifid_annul;
    logic [1:0]  pc_sel, fwd_a, fwd_b, fwd_d;
    logic [15:0] stall_cnt;

    logic        pc_le4, npc_le4, ifid_le4, cu_nop_sel4, ifid_annul4;
    logic [1:0]  pc_sel4, fwd_a4, fwd_b4, fwd_d4;
    logic [3:0]  stall_cnt4;

    always #5 Clk = ~Clk;

    pipeline_hazard_controller dut (
        .Clk(Clk), .R(R),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_uses_rd(id_uses_rd),
        .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
        .id_b_instr(id_b_instr), .id_call_instr(id_call_instr), .id_jmpl_instr(id_jmpl_instr),
        .id_cond_true(id_cond_true), .id_ba(id_ba), .id_29_a(id_29_a),
        .pc_le(pc_le), .npc_le(npc_le), .ifid_le(ifid_le),
        .cu_nop_sel(cu_nop_sel), .ifid_annul(ifid_annul), .pc_sel(pc_sel),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d), .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run
    pipeline_hazard_controller #(.REG_W(5), .CNT_W(4)) dut_sat (
        .Clk(Clk), .R(R),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_uses_rd(id_uses_rd),
        .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
        .id_b_instr(id_b_instr), .id_call_instr(id_call_instr), .id_jmpl_instr(id_jmpl_instr),
        .id_cond_true(id_cond_true), .id_ba(id_ba), .id_29_a(id_29_a),
        .pc_le(pc_le4), .npc_le(npc_le4), .ifid_le(ifid_le4),
        .cu_nop_sel(cu_nop_sel4), .ifid_annul(ifid_annul4), .pc_sel(pc_sel4),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .fwd_d(fwd_d4), .stall_cnt(stall_cnt4)
    );

    // Reference model: hist[0] is the newest instruction to leave ID
    typedef struct {
        int rd;
        bit wr;
        bit ld;
    } ent_t;

    ent_t hist[3];
    bit   m_stalled;
    bit   m_annul_prev;
    int   m_cnt;
    int   m_cnt4;
    bit   e_hz;
    bit   e_annul;
    bit   prev_dut_stall;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_fwd(input bit u, input int src);
        if (!u) return 0;
        for (int k = 0; k < 3; k++) begin
            if (hist[k].wr && hist[k].rd != 0 && hist[k].rd == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit reads(input int r);
        return (id_uses_rs1 && int'(id_rs1) == r) ||
               (id_uses_rs2 && int'(id_rs2) == r) ||
               (id_uses_rd  && int'(id_rd)  == r);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{rd: 0, wr: 1'b0, ld: 1'b0};
        m_stalled    = 1'b0;
        m_annul_prev = 1'b0;
        m_cnt        = 0;
        m_cnt4       = 0;
    endtask

    // Evaluate the model for this cycle's inputs and compare on the falling edge
    task automatic settle();
        logic [31:0] fa, fb, fd, le, nop, ann, ps;
        bit hz;
        @(negedge Clk);
        hz = 1'b0; fa = 0; fb = 0; fd = 0;
        if (R) begin
            fa = exp_fwd(id_uses_rs1, int'(id_rs1));
            fb = exp_fwd(id_uses_rs2, int'(id_rs2));
            fd = exp_fwd(id_uses_rd,  int'(id_rd));
            hz = hist[0].ld && hist[0].wr && hist[0].rd != 0 && reads(hist[0].rd);
        end
        if (!R) begin
            le = 1; nop = 1; ann = 0; ps = 0;
        end else if (hz) begin
            le = 0; nop = 1; ann = 0; ps = 0;
        end else begin
            le  = 1; nop = 0;
            ps  = id_jmpl_instr ? 2 : ((id_call_instr || (id_b_instr && id_cond_true)) ? 1 : 0);
            ann = (id_b_instr && id_29_a && (!id_cond_true || id_ba)) ? 1 : 0;
        end
        e_hz    = hz;
        e_annul = ann[0];
        chk("pc_le",      32'(pc_le),      le);
        chk("npc_le",     32'(npc_le),     le);
        chk("ifid_le",    32'(ifid_le),    le);
        chk("cu_nop_sel", 32'(cu_nop_sel), nop);
        chk("ifid_annul", 32'(ifid_annul), ann);
        chk("pc_sel",     32'(pc_sel),     ps);
        chk("fwd_a",      32'(fwd_a),      fa);
        chk("fwd_b",      32'(fwd_b),      fb);
        chk("fwd_d",      32'(fwd_d),      fd);
        chk("stall_cnt",  32'(stall_cnt),  32'(m_cnt));
        chk("stall_cnt4", 32'(stall_cnt4), 32'(m_cnt4));
        chk("double_stall", 32'(prev_dut_stall && R && !pc_le), 32'(0));
    endtask

    // Apply the clock edge to the model and the DUT
    task automatic advance();
        ent_t n;
        if (!R) begin
            model_reset();
        end else begin
            if (e_hz || m_annul_prev) n = '{rd: 0, wr: 1'b0, ld: 1'b0};
            else n = '{rd: int'(id_rd), wr: id_rf_enable, ld: id_load_instr};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = n;
            if (e_hz && !m_stalled) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_annul_prev = e_annul;
            m_stalled    = e_hz;
        end
        prev_dut_stall = R && !pc_le;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_nop();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_uses_rd = 1'b0;
        id_rf_enable = 1'b0; id_load_instr = 1'b0;
        id_b_instr = 1'b0; id_call_instr = 1'b0; id_jmpl_instr = 1'b0;
        id_cond_true = 1'b0; id_ba = 1'b0; id_29_a = 1'b0;
    endtask

    task automatic set_alu(input int rd, input int rs1, input int rs2, input bit ld);
        set_nop();
        id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_uses_rs1 = 1'b1; id_uses_rs2 = !ld;
        id_rf_enable = 1'b1; id_load_instr = ld;
    endtask

    task automatic set_use1(input int rs1);
        set_nop();
        id_rs1 = 5'(rs1); id_uses_rs1 = 1'b1; id_rd = 5'd9; id_rf_enable = 1'b1;
    endtask

    task automatic rand_instr();
        int kind;
        R = ($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0;
        if (m_stalled) return;            // IF/ID is holding the stalled instruction
        if (m_annul_prev) begin
            set_nop();                    // delay slot squashed into a NOP
            return;
        end
        id_rs1 = 5'($urandom_range(0, 7));
        id_rs2 = 5'($urandom_range(0, 7));
        id_rd  = 5'($urandom_range(0, 7));
        id_uses_rs1 = 1'($urandom_range(0, 1));
        id_uses_rs2 = 1'($urandom_range(0, 1));
        id_uses_rd  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        id_rf_enable  = 1'($urandom_range(0, 1));
        id_load_instr = id_rf_enable & 1'($urandom_range(0, 1));
        kind = $urandom_range(0, 5);
        id_b_instr    = (kind == 1 || kind == 2) ? 1'b1 : 1'b0;
        id_call_instr = (kind == 3) ? 1'b1 : 1'b0;
        id_jmpl_instr = (kind == 4) ? 1'b1 : 1'b0;
        id_ba         = id_b_instr & ($urandom_range(0, 3) == 0);
        id_cond_true  = id_ba | 1'($urandom_range(0, 1));
        id_29_a       = 1'($urandom_range(0, 1));
    endtask

    initial begin
        R = 1'b0;
        set_nop();
        model_reset();
        prev_dut_stall = 1'b0;
        @(posedge Clk);
        #1;

        // Reset state with forced outputs
        settle();
        chk("rst_cu_nop", 32'(cu_nop_sel), 32'(1));
        advance();
        R = 1'b1;

        // Forward from EX, and %g0 never forwards
        set_alu(3, 1, 2, 1'b0); settle(); advance();
        set_use1(3); settle(); chk("fwd_ex", 32'(fwd_a), 32'(1)); chk("fwd_ex_nostall", 32'(pc_le), 32'(1)); advance();
        set_alu(0, 1, 2, 1'b0); settle(); advance();
        set_use1(0); settle(); chk("fwd_g0", 32'(fwd_a), 32'(0)); advance();

        // MEM beats WB for the same register; store data source too
        set_alu(5, 1, 2, 1'b0); settle(); advance();
        set_alu(5, 1, 2, 1'b0); settle(); advance();
        set_nop(); settle(); advance();
        set_nop(); id_rs2 = 5'd5; id_uses_rs2 = 1'b1; id_rd = 5'd5; id_uses_rd = 1'b1;
        settle(); chk("prio_b", 32'(fwd_b), 32'(2)); chk("prio_d", 32'(fwd_d), 32'(2)); advance();

        // Load-use: one bubble, then forward from MEM
        set_alu(7, 1, 0, 1'b1); settle(); advance();
        set_use1(7); settle();
        chk("lu_pc_le", 32'(pc_le), 32'(0)); chk("lu_nop", 32'(cu_nop_sel), 32'(1));
        chk("lu_cnt0", 32'(stall_cnt), 32'(0)); advance();
        settle();
        chk("lu_fwd_mem", 32'(fwd_a), 32'(2)); chk("lu_pc_le1", 32'(pc_le), 32'(1));
        chk("lu_cnt1", 32'(stall_cnt), 32'(1)); advance();

        // Annul cases: bne,a untaken / ba,a / be taken without annul
        set_nop(); id_b_instr = 1'b1; id_29_a = 1'b1; settle();
        chk("bne_a_sel", 32'(pc_sel), 32'(0)); chk("bne_a_ann", 32'(ifid_annul), 32'(1)); advance();
        set_nop(); settle(); advance();
        set_nop(); id_b_instr = 1'b1; id_29_a = 1'b1; id_ba = 1'b1; id_cond_true = 1'b1; settle();
        chk("ba_a_sel", 32'(pc_sel), 32'(1)); chk("ba_a_ann", 32'(ifid_annul), 32'(1)); advance();
        set_nop(); settle(); advance();
        set_nop(); id_b_instr = 1'b1; id_cond_true = 1'b1; settle();
        chk("be_sel", 32'(pc_sel), 32'(1)); chk("be_ann", 32'(ifid_annul), 32'(0)); advance();

        // Stall beats jmpl; jmpl resolves in the following cycle
        set_alu(4, 1, 0, 1'b1); settle(); advance();
        set_use1(4); id_jmpl_instr = 1'b1; settle();
        chk("jmpl_stall_sel", 32'(pc_sel), 32'(0)); chk("jmpl_stall_le", 32'(pc_le), 32'(0)); advance();
        settle(); chk("jmpl_sel", 32'(pc_sel), 32'(2)); advance();

        // Reset during STALL
        set_alu(6, 1, 0, 1'b1); settle(); advance();
        set_nop(); id_rs2 = 5'd6; id_uses_rs2 = 1'b1; settle(); advance();
        R = 1'b0; settle();
        chk("rst_le", 32'(pc_le), 32'(1)); chk("rst_fwd", 32'(fwd_b), 32'(0)); advance();
        R = 1'b1; id_rs1 = 5'd6; id_uses_rs1 = 1'b1; settle();
        chk("post_rst_cnt", 32'(stall_cnt), 32'(0)); chk("post_rst_fwd", 32'(fwd_b), 32'(0));
        chk("post_rst_le", 32'(pc_le), 32'(1)); advance();

        // Twenty load-use pairs: narrow counter saturates
        for (int i = 0; i < 20; i++) begin
            set_alu(7, 1, 0, 1'b1); settle(); advance();
            set_use1(7); settle(); advance();
            settle(); advance();
        end
        set_nop(); settle();
        chk("sat_cnt4", 32'(stall_cnt4), 32'(15)); chk("cnt20", 32'(stall_cnt), 32'(20)); advance();

        // Random instruction streams
        for (int i = 0; i < 2000; i++) begin
            rand_instr();
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
